// File: rtl/counter_arbiter.sv
// Round-robin arbiter sharing one counter between NUM_REQ requesters, with a
// watchdog that aborts runs whose done never arrives.
module counter_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int VALUE_WIDTH    = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     ack,
    output logic [VALUE_WIDTH-1:0] result,
    output logic                   timeout,
    output logic                   cnt_start,
    input  logic                   cnt_enabled,
    input  logic                   cnt_done,
    input  logic [VALUE_WIDTH-1:0] cnt_value,
    output logic [2:0]             state
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]      TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0]      IDX_LAST = IW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        RUN       = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t        st;
    logic [IW-1:0] last;
    logic [IW-1:0] winner;
    logic [IW-1:0] pick;
    logic          pick_valid;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    // Handshake: a requester holds req high until it sees its one-cycle ack;
    // grant marks the owner from START through DONE, result/timeout are valid
    // in the ack cycle and held until the next ack.
    assign state   = st;
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return IW'(sum);
    endfunction

    // Search starts just after the last served index so every requester gets a turn.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!pick_valid && req[wrap_idx(last, k)]) begin
                pick       = wrap_idx(last, k);
                pick_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st        <= IDLE;
            grant     <= '0;
            ack       <= '0;
            cnt_start <= 1'b0;
            result    <= '0;
            timeout   <= 1'b0;
            last      <= IDX_LAST;
            winner    <= '0;
            tmo_cnt   <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (pick_valid) begin
                        winner    <= pick;
                        grant     <= ONE << pick;
                        cnt_start <= 1'b1;
                        st        <= START;
                    end
                end
                START: begin
                    cnt_start <= 1'b0;
                    tmo_cnt   <= '0;
                    st        <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // A done still high from the previous run is deliberately ignored here.
                    if (tmo_hit) begin
                        result  <= '0;
                        timeout <= 1'b1;
                        ack     <= grant;
                        st      <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (cnt_enabled) st <= RUN;
                    end
                end
                RUN: begin
                    if (cnt_done) begin
                        result  <= cnt_value;
                        timeout <= 1'b0;
                        ack     <= grant;
                        st      <= DONE;
                    end else if (tmo_hit) begin
                        result  <= '0;
                        timeout <= 1'b1;
                        ack     <= grant;
                        st      <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DONE: begin
                    ack   <= '0;
                    grant <= '0;
                    last  <= winner;
                    st    <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Shares one `counter` instance between `NUM_REQ` independent requesters, in the `clock_divider` → `counter` path of the board tops.
- Grants requesters round-robin and issues the counter's one-cycle `start`.
- Tracks the counter's `enabled`/`done` handshake and returns the final `value` to the granted requester with an acknowledge pulse.
- A watchdog aborts a run whose `done` never arrives, so a stuck counter cannot lock out the other requesters.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `VALUE_WIDTH`, default 8: width of counter value and result.
- `TIMEOUT_CYCLES`, default 1024: clock cycles allowed from `cnt_start` to `cnt_done` before abort; must be ≥ 4.

Ports:
- `clock`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `req`  in  NUM_REQ: level request per requester; held high until its `ack`.
- `grant`  out  NUM_REQ: one-hot owner of the counter; all zero when idle.
- `ack`  out  NUM_REQ: one-cycle pulse to the owner at end of service.
- `result`  out  VALUE_WIDTH: captured counter value; valid in the `ack` cycle, held until the next `ack`.
- `timeout`  out  1: high in the `ack` cycle if the run was aborted.
- `cnt_start`  out  1: one-cycle start to the counter.
- `cnt_enabled`  in  1: counter running.
- `cnt_done`  in  1: counter finished; may be a level or a pulse.
- `cnt_value`  in  VALUE_WIDTH: counter value.

## Operation
- FSM states: IDLE, START, WAIT_BUSY, RUN, DONE.
- **IDLE:** if any `req` bit is high, select the winner and go to START.
  - Search starts at index `last+1` and wraps modulo NUM_REQ.
  - `last` is the index of the previously served requester; reset value NUM_REQ-1, so index 0 wins first.
- **START:** `grant` = one-hot winner; `cnt_start`=1; timeout counter cleared; go to WAIT_BUSY.
- **WAIT_BUSY:** ignore `cnt_done` (it may still be high from the previous run). Go to RUN when `cnt_enabled`=1.
- **RUN:** when `cnt_done`=1, capture `cnt_value` into `result`, clear `timeout`, go to DONE.
- **Abort:** in WAIT_BUSY or RUN, if the timeout counter reaches TIMEOUT_CYCLES-1, set `result`=0 and `timeout`=1, then go to DONE.
- **DONE:** `ack[winner]`=1 for this cycle only; `last` ← winner; go to IDLE.
- `grant` stays constant from START through DONE and is all-zero in IDLE.
- A requester that drops `req` mid-service is not cancelled: the run completes and `ack` still pulses.
- Requests arriving during service wait; they are evaluated in the next IDLE cycle.
- Timeout counter: width clog2(TIMEOUT_CYCLES); it never wraps, because the abort fires first.

## Timing
- Reset: state=IDLE; `grant`=0, `ack`=0, `cnt_start`=0, `result`=0, `timeout`=0, `last`=NUM_REQ-1.
- Reset asserted mid-run: outputs return to reset values immediately (asynchronous).
  - The counter itself is not stopped by this block; the next `cnt_start` restarts it.
- `req` seen in IDLE at cycle N → `grant` and `cnt_start` high at N+1, WAIT_BUSY at N+2.
- `cnt_done` first seen high in RUN at cycle M → `ack` and `result` at M+1, IDLE at M+2.
- Minimum service time is 5 cycles (IDLE, START, WAIT_BUSY, RUN, DONE), reached when `cnt_enabled` and `cnt_done` each respond in one cycle.
- Back-to-back service: the next grant appears 2 cycles after an `ack`.
- `cnt_enabled` and `cnt_done` both high in the same WAIT_BUSY cycle: go to RUN only; `done` is sampled in the following cycle.
- Abort: `ack` with `timeout`=1 exactly TIMEOUT_CYCLES+1 cycles after the `cnt_start` cycle.

## Test plan
- **Single requester:** reset; `req`=0001; counter model goes enabled 1 cycle after start and done with value 8'h2A 10 cycles later.
  - Expect `grant`=0001 with `cnt_start` on the next cycle.
  - Expect `ack`=0001, `result`=8'h2A, `timeout`=0.
- **Round-robin fairness:** `req`=1111 held (each bit re-raised after its ack).
  - Grant order must be 0,1,2,3,0.
  - No `grant` bit may ever be high in the same cycle as another.
- **Stale done:** counter model holds `done`=1 from the previous run until `enabled` rises.
  - Arbiter must not ack early; `result` must equal the new run's value.
- **Timeout:** TIMEOUT_CYCLES=16; counter model never asserts `done`.
  - Expect `ack` with `timeout`=1 and `result`=0 exactly 17 cycles after `cnt_start`.
  - The next pending requester must then be granted.
- **Withdrawn request:** drop `req[2]` one cycle after its grant.
  - Run still completes; `ack`=0100 pulses once; `req[2]` is not re-granted.
- **Reset mid-run:** assert `reset` during RUN.
  - `grant`, `ack`, `cnt_start`, `result`, `timeout` go to 0 immediately.
  - After release with `req`=1000, requester 3 is granted, since it is the only active request.
